// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch stage feeding decode.
// Issues sequential word-aligned fetches under a credit limit of DEPTH. Returned words
// are queued with their PCs, and the head entry goes to decode with pre-sliced fields.
// A redirect flushes the queue and marks every in-flight request stale.
// Optional: define FETCH_PERF_EN to add saturating perf_fetched/perf_dropped counters.
module fetch_buffer #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [6:0]      dec_opcode,
    output logic [2:0]      dec_funct3,
    output logic [6:0]      dec_funct7
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    cnt_t            outst_q, outst_d;
    cnt_t            drop_q, drop_d;
    cnt_t            count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [XLEN-1:0] fifo_instr_q [DEPTH];
    logic [XLEN-1:0] fifo_pc_q    [DEPTH];

    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redirect_tgt;
    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_stale;
    logic            push;
    logic            pop;
    logic            unused_redirect_lsb;

    // Redirect targets are forced to word alignment; the low bits are simply dropped.
    assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Outstanding requests plus queued entries never exceed DEPTH, so a push can never
    // find the queue full.
    assign credit_used    = {1'b0, outst_q} + {1'b0, count_q};
    assign imem_req_valid = !rst && !redirect && (credit_used < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_fire  = imem_rsp_valid && (outst_q != '0);
    assign rsp_stale = rsp_fire && (drop_q != '0);
    assign push      = rsp_fire && !rsp_stale && !redirect;
    assign pop       = (count_q != '0) && dec_ready && !redirect;

    // Decode view of the queue head; NOP with PC 0 when empty.
    assign dec_valid  = (count_q != '0);
    assign dec_instr  = dec_valid ? fifo_instr_q[rd_ptr_q] : NOP;
    assign dec_pc     = dec_valid ? fifo_pc_q[rd_ptr_q] : '0;
    assign dec_opcode = dec_instr[6:0];
    assign dec_funct3 = dec_instr[14:12];
    assign dec_funct7 = dec_instr[31:25];

    // Next-state for PCs, credit counters and queue pointers.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect) begin
            // Everything still in flight after this cycle's response becomes stale.
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            outst_d    = outst_q - cnt_t'(rsp_fire);
            drop_d     = outst_q - cnt_t'(rsp_fire);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            outst_d = outst_q + cnt_t'(req_fire) - cnt_t'(rsp_fire);
            if (rsp_stale) begin
                drop_d = drop_q - cnt_t'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Queue storage; contents are qualified by count_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
            fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [32:0] fetched_sum;
    logic [32:0] dropped_sum;
    logic [CW:0] dropped_inc;

    // Dropped work is flushed entries plus any response discarded on a redirect,
    // or a stale response otherwise.
    always_comb begin
        dropped_inc = redirect ? ({1'b0, count_q} + (CW + 1)'(rsp_fire))
                               : (CW + 1)'(rsp_stale);
        fetched_sum = {1'b0, perf_fetched} + 33'(pop);
        dropped_sum = {1'b0, perf_dropped} + 33'(dropped_inc);
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            perf_fetched <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
            perf_dropped <= dropped_sum[32] ? 32'hFFFF_FFFF : dropped_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a latency-programmable memory model answers requests,
// directed scenarios push hand-computed {pc, instr} expectations, and a monitor checks
// every decode handshake against them.
`timescale 1ns/1ps
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    fetch_buffer #(
        .XLEN    (32),
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .dec_opcode    (dec_opcode),
        .dec_funct3    (dec_funct3),
        .dec_funct7    (dec_funct7)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_dropped  (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          lat = 1;
    int          accepts = 0;
    int          total = 0;
    int          bad = 0;
    int          hs_cnt = 0;
    int          first_hs = 0;
    int          last_hs = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h00A0_0093 ^ (a << 10) ^ (a << 23);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = mem_word(a);
        exp_q.push_back(e);
    endtask

    // Memory: records accepted requests and returns them in order after lat cycles.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cyc + lat);
                accepts++;
            end
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr.pop_front());
                pend_due.delete(0);
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor: every decode handshake is checked against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (dec_valid && dec_ready && !redirect && !rst) begin
                hs_cnt++;
                if (hs_cnt == 1) first_hs = cyc;
                last_hs = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_dec: got pc=%h, required no handshake", dec_pc);
                end else begin
                    e = exp_q.pop_front();
                    check32("dec_pc", dec_pc, e.pc);
                    check32("dec_instr", dec_instr, e.instr);
                    check32("dec_opcode", {25'd0, dec_opcode}, {25'd0, e.instr[6:0]});
                    check32("dec_funct3", {29'd0, dec_funct3}, {29'd0, e.instr[14:12]});
                    check32("dec_funct7", {25'd0, dec_funct7}, {25'd0, e.instr[31:25]});
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        dec_ready      = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        pend_addr.delete();
        pend_due.delete();
        exp_q.delete();
        accepts = 0;
        hs_cnt  = 0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        dec_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d entries left, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int n;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check32("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check32("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        check32("rst_dec_instr", dec_instr, 32'h0000_0013);
        check32("rst_dec_pc", dec_pc, 32'd0);

        // Streaming with 1-cycle memory and decode always ready.
        do_reset();
        lat       = 1;
        dec_ready = 1'b1;
        rst       = 1'b0;
        s         = cyc;
        #1;
        check32("s1_first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check32("s1_first_req_addr", imem_req_addr, 32'h0);
        for (int i = 0; i < 12; i++) push_exp(32'(i * 4));
        n = 0;
        while (!dec_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check32("s1_first_valid_lat", 32'(cyc - s), 32'd2);
        check32("s1_opcode", {25'd0, dec_opcode}, 32'h13);
        check32("s1_funct3", {29'd0, dec_funct3}, 32'h0);
        check32("s1_funct7", {25'd0, dec_funct7}, 32'h0);
        wait_drain("s1", 40);
        check32("s1_gapless", 32'(last_hs - first_hs), 32'd11);

        // Decode stalled: exactly DEPTH requests, queue full, then ordered drain.
        do_reset();
        lat = 1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check32("s2_accepts", 32'(accepts), 32'd4);
        check32("s2_req_blocked", {31'd0, imem_req_valid}, 32'd0);
        check32("s2_full_valid", {31'd0, dec_valid}, 32'd1);
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        dec_ready = 1'b1;
        wait_drain("s2", 20);
        check32("s2_gapless", 32'(last_hs - first_hs), 32'd3);

        // Redirect with three requests in flight on a 3-cycle memory.
        do_reset();
        lat = 3;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check32("s3_in_flight", 32'(accepts), 32'd3);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check32("s3_redir_no_req", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check32("s3_post_valid", {31'd0, dec_valid}, 32'd0);
        check32("s3_post_addr", imem_req_addr, 32'h100);
        push_exp(32'h100);
        push_exp(32'h104);
        push_exp(32'h108);
        dec_ready = 1'b1;
        wait_drain("s3", 40);
`ifdef FETCH_PERF_EN
        repeat (2) @(negedge clk);
        #1;
        check32("s3_perf_dropped", perf_dropped, 32'd3);
        check32("s3_perf_fetched", perf_fetched, 32'(hs_cnt));
`endif

        // Redirect coincident with a response and a pop; unaligned target.
        do_reset();
        lat       = 1;
        dec_ready = 1'b1;
        rst       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        #1;
        check32("s4_pre_valid", {31'd0, dec_valid}, 32'd1);
        check32("s4_pre_pc", dec_pc, 32'h0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check32("s4_flushed", {31'd0, dec_valid}, 32'd0);
        check32("s4_aligned_addr", imem_req_addr, 32'h100);
        check32("s4_req_valid", {31'd0, imem_req_valid}, 32'd1);
        push_exp(32'h100);
        push_exp(32'h104);
        wait_drain("s4", 20);

        // Reset with two requests outstanding; late responses must be ignored.
        do_reset();
        lat = 5;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check32("s5_two_out", 32'(accepts), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        check32("s5_restart_valid", {31'd0, imem_req_valid}, 32'd1);
        check32("s5_restart_addr", imem_req_addr, 32'h0);
        repeat (5) @(negedge clk);
        #1;
        check32("s5_late_ignored", {31'd0, dec_valid}, 32'd0);
        check32("s5_empty_instr", dec_instr, 32'h0000_0013);
        check32("s5_empty_pc", dec_pc, 32'h0);
        check32("s5_credit_intact", {31'd0, imem_req_valid}, 32'd1);
        check32("s5_addr_held", imem_req_addr, 32'h0);
        lat            = 1;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        push_exp(32'h0);
        push_exp(32'h4);
        wait_drain("s5", 20);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
